// File: rtl/mfp_ahb_uart_tx.sv
// rtl/mfp_ahb_uart_tx.sv - AHB-Lite 8N1 UART transmitter with byte FIFO, status and drain interrupt
module mfp_ahb_uart_tx #(
    parameter int DEPTH_LOG2      = 4,
    parameter int CLK_DIV_DEFAULT = 434
) (
    input  logic        HCLK,
    input  logic        SI_Reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        UART_TX,
    output logic        IRQ
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [15:0]         DIV_RESET = 16'(CLK_DIV_DEFAULT);
    localparam logic [15:0]         DIV_MIN   = 16'd2;

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_DIVISOR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Bus data-phase tracking
    logic        dp_valid;
    logic        dp_write;
    logic [1:0]  dp_addr;
    logic        accept;

    // Register strobes, all qualified by the data phase
    logic        wr_txdata;
    logic        wr_divisor;
    logic        rd_status;
    logic        rd_active;

    // FIFO
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  overflow;
    logic                  ovf;

    // Control registers
    logic [15:0] divisor;

    // Transmit engine
    state_t      state;
    logic [7:0]  shift;
    logic [15:0] period;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic        bit_end;
    logic        frame_load;
    logic        busy;
    logic        line_idle;

    logic [31:0] status_word;

    // Address-phase fields that carry no meaning for this slave
    logic unused_bus_bits;
    assign unused_bus_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    assign accept     = HSEL & HTRANS[1] & HREADY;
    assign wr_txdata  = dp_valid &  dp_write & (dp_addr == A_TXDATA);
    assign wr_divisor = dp_valid &  dp_write & (dp_addr == A_DIVISOR);
    assign rd_active  = dp_valid & ~dp_write;
    assign rd_status  = rd_active & (dp_addr == A_STATUS);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign busy       = (state != S_IDLE);

    // A new frame begins from IDLE, or straight out of the last stop-bit cycle
    assign bit_end    = (baud_cnt == 16'd0);
    assign frame_load = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
    assign pop        = frame_load;

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign push       = wr_txdata & (~fifo_full | pop);
    assign overflow   = wr_txdata & ~push;

    // Capture the address phase so the data phase knows what to do
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 2'd0;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR[3:2];
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= HWDATA[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a dropped byte wins over a STATUS read in the same cycle
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (ovf & ~rd_status) | overflow;
        end
    end

    // Bit-period divisor, clamped so the baud counter always has at least two cycles
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            divisor <= DIV_RESET;
        end else if (wr_divisor) begin
            divisor <= (HWDATA[15:0] < DIV_MIN) ? DIV_MIN : HWDATA[15:0];
        end
    end

    // Frame sequencer: the divisor is sampled only when a frame is loaded
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            state    <= S_IDLE;
            shift    <= 8'd0;
            period   <= DIV_RESET;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_load) begin
                        shift    <= mem[rd_ptr];
                        period   <= divisor;
                        baud_cnt <= divisor - 16'd1;
                        bit_cnt  <= 3'd0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= period - 16'd1;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= period - 16'd1;
                        shift    <= {1'b0, shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (frame_load) begin
                            shift    <= mem[rd_ptr];
                            period   <= divisor;
                            baud_cnt <= divisor - 16'd1;
                            bit_cnt  <= 3'd0;
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Serial line flop; follows the sequencer one cycle later so the pin is glitch-free
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            UART_TX <= 1'b1;
        end else begin
            case (state)
                S_START: UART_TX <= 1'b0;
                S_DATA:  UART_TX <= shift[0];
                default: UART_TX <= 1'b1;
            endcase
        end
    end

    // Drain interrupt; rises only after the stop bit has fully left the pin
    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            line_idle <= 1'b1;
            IRQ       <= 1'b1;
        end else begin
            line_idle <= (state == S_IDLE);
            IRQ       <= fifo_empty & (state == S_IDLE) & line_idle;
        end
    end

    // STATUS word assembly
    always_comb begin
        status_word                    = 32'd0;
        status_word[0]                 = busy;
        status_word[1]                 = fifo_full;
        status_word[2]                 = fifo_empty;
        status_word[3]                 = ovf;
        status_word[8 +: DEPTH_LOG2+1] = count;
    end

    // Read data mux; quiet outside a read data phase
    always_comb begin
        HRDATA = 32'd0;
        if (rd_active) begin
            case (dp_addr)
                A_STATUS:  HRDATA = status_word;
                A_DIVISOR: HRDATA = {16'd0, divisor};
                default:   HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// tb/tb_mfp_ahb_uart_tx.sv - scoreboard bench for mfp_ahb_uart_tx
module tb_mfp_ahb_uart_tx;

    logic        HCLK = 1'b0;
    logic        SI_Reset;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        UART_TX;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         period;
        int         gap;
    } frame_t;

    frame_t      frame_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  wbuf[0:31];

    mfp_ahb_uart_tx #(.DEPTH_LOG2(4), .CLK_DIV_DEFAULT(434)) dut (
        .HCLK     (HCLK),
        .SI_Reset (SI_Reset),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HREADY   (HREADY),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .UART_TX  (UART_TX),
        .IRQ      (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] data, input int period, input int gap);
        frame_t f;
        f.data   = data;
        f.period = period;
        f.gap    = gap;
        frame_q.push_back(f);
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'd0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = addr;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = addr;
        @(posedge HCLK); #1;
        bus_idle();
        @(posedge HCLK); #1;
    endtask

    task automatic write_burst(input int n);
        for (int i = 0; i < n; i++) begin
            HSEL   = 1'b1;
            HTRANS = 2'b10;
            HWRITE = 1'b1;
            HADDR  = 32'h0;
            if (i > 0) HWDATA = {24'd0, wbuf[i-1]};
            @(posedge HCLK); #1;
        end
        bus_idle();
        HWDATA = {24'd0, wbuf[n-1]};
        @(posedge HCLK); #1;
    endtask

    task automatic wait_irq(input int bound, input string name);
        int k;
        k = 0;
        while (IRQ !== 1'b1 && k < bound) begin
            @(negedge HCLK);
            k++;
        end
        check(name, {31'd0, IRQ}, 32'd1);
    endtask

    // Line monitor: decodes every frame cycle by cycle against the expected queue
    initial begin : line_mon
        frame_t     cur;
        int         j;
        int         b;
        int         idle_cnt;
        logic       in_frame;
        logic       ignore;
        logic       stable;
        logic [9:0] obs;
        logic [9:0] pat;
        in_frame = 1'b0;
        ignore   = 1'b0;
        idle_cnt = 0;
        j        = 0;
        stable   = 1'b1;
        obs      = '0;
        pat      = '0;
        cur.data = 8'd0; cur.period = 1; cur.gap = -1;
        forever begin
            @(negedge HCLK);
            if (SI_Reset === 1'b1) begin
                in_frame = 1'b0;
                idle_cnt = 0;
            end else begin
                if (!in_frame) begin
                    if (UART_TX === 1'b0) begin
                        if (frame_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: start bit at %0t, no byte expected", $time);
                            cur.data = 8'd0; cur.period = 1; cur.gap = -1;
                            ignore = 1'b1;
                        end else begin
                            cur = frame_q.pop_front();
                            ignore = 1'b0;
                            if (cur.gap >= 0) check("frame_gap", idle_cnt, cur.gap);
                        end
                        pat      = {1'b1, cur.data, 1'b0};
                        obs      = '0;
                        stable   = 1'b1;
                        j        = 0;
                        in_frame = 1'b1;
                    end else begin
                        idle_cnt++;
                    end
                end
                if (in_frame) begin
                    b = j / cur.period;
                    if (j % cur.period == 0) obs[b] = UART_TX;
                    else if (UART_TX !== obs[b]) stable = 1'b0;
                    j++;
                    if (j == 10 * cur.period) begin
                        in_frame = 1'b0;
                        idle_cnt = 0;
                        if (!ignore) check("frame", {21'd0, stable, obs}, {21'd0, 1'b1, pat});
                    end
                end
            end
        end
    end

    // Read monitor: compares HRDATA in each read data phase, and zero right after it
    initial begin : rd_mon
        logic pend;
        logic prev_pend;
        prev_pend = 1'b0;
        forever begin
            @(posedge HCLK);
            pend = HSEL && HTRANS[1] && HREADY && !HWRITE;
            @(negedge HCLK);
            if (pend) begin
                if (rd_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected: actual=0x%08h with no read expected", HRDATA);
                end else begin
                    check(rd_name_q.pop_front(), HRDATA, rd_exp_q.pop_front());
                end
            end else if (prev_pend) begin
                check("hrdata_idle", HRDATA, 32'd0);
            end
            prev_pend = pend;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int fall_k;
        int lo_k;
        int hi_k;
        int w;

        SI_Reset = 1'b1;
        HREADY   = 1'b1;
        HSIZE    = 3'b010;
        HWDATA   = 32'd0;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1;
        check("reset_tx", {31'd0, UART_TX}, 32'd1);
        check("reset_irq", {31'd0, IRQ}, 32'd1);
        check("reset_hrdata", HRDATA, 32'd0);
        SI_Reset = 1'b0;
        @(posedge HCLK); #1;

        ahb_read(32'h4, 32'h0000_0004, "status_reset");
        ahb_read(32'h8, 32'd434, "divisor_reset");
        ahb_read(32'h0, 32'd0, "txdata_reads_zero");
        ahb_read(32'hC, 32'd0, "reserved_reads_zero");

        // Write with HREADY low must be ignored
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0; HREADY = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        bus_idle();
        HWDATA = 32'h77;
        @(posedge HCLK); #1;
        ahb_read(32'h4, 32'h0000_0004, "status_hready_low");

        // Single byte, period 4
        ahb_write(32'h8, 32'd4);
        push_frame(8'hA5, 4, -1);
        ahb_write(32'h0, 32'hA5);
        fall_k = -1; lo_k = -1; hi_k = -1;
        for (int k = 0; k < 90; k++) begin
            @(negedge HCLK);
            if (fall_k < 0 && UART_TX === 1'b0) fall_k = k;
            if (lo_k < 0 && IRQ === 1'b0) lo_k = k;
            if (lo_k >= 0 && hi_k < 0 && IRQ === 1'b1) hi_k = k;
        end
        check("tx_fall_latency", fall_k, 32'd2);
        check("irq_fall_latency", lo_k, 32'd1);
        check("irq_rise_after_fall", hi_k - fall_k, 32'd41);

        // Back-to-back at period 2
        ahb_write(32'h8, 32'd2);
        push_frame(8'h00, 2, -1);
        push_frame(8'hFF, 2, 0);
        wbuf[0] = 8'h00;
        wbuf[1] = 8'hFF;
        write_burst(2);
        wait_irq(200, "irq_after_b2b");

        // Divisor clamp and upper-bit masking
        ahb_write(32'h8, 32'd1);
        ahb_read(32'h8, 32'd2, "divisor_clamp_1");
        ahb_write(32'h8, 32'd0);
        ahb_read(32'h8, 32'd2, "divisor_clamp_0");
        ahb_write(32'h8, 32'hABCD_0003);
        ahb_read(32'h8, 32'd3, "divisor_upper_masked");

        // Mid-frame divisor change
        ahb_write(32'h8, 32'd2);
        push_frame(8'h3C, 2, -1);
        push_frame(8'hC3, 8, 0);
        ahb_write(32'h0, 32'h3C);
        ahb_write(32'h0, 32'hC3);
        ahb_write(32'h8, 32'd8);
        ahb_read(32'h8, 32'd8, "divisor_midframe");
        wait_irq(400, "irq_after_midframe");

        // Overflow: 18 bytes, 17 survive
        ahb_write(32'h8, 32'd100);
        for (int i = 0; i < 18; i++) wbuf[i] = 8'h40 + 8'(i);
        push_frame(8'h40, 100, -1);
        for (int i = 1; i < 17; i++) push_frame(8'h40 + 8'(i), 4, 0);
        write_burst(18);
        ahb_read(32'h4, 32'h0000_100B, "status_ovf_set");
        ahb_read(32'h4, 32'h0000_1003, "status_ovf_cleared");
        ahb_write(32'h8, 32'd4);
        wait_irq(3000, "irq_after_overflow");
        ahb_read(32'h4, 32'h0000_0004, "status_drained");

        // Reset in the middle of a data bit with bytes queued
        ahb_write(32'h8, 32'd8);
        push_frame(8'h00, 8, -1);
        wbuf[0] = 8'h00; wbuf[1] = 8'h00; wbuf[2] = 8'h00;
        write_burst(3);
        w = 0;
        while (UART_TX !== 1'b0 && w < 20) begin
            @(negedge HCLK);
            w++;
        end
        repeat (10) @(negedge HCLK);
        check("tx_low_before_reset", {31'd0, UART_TX}, 32'd0);
        #2;
        SI_Reset = 1'b1;
        #1;
        check("tx_async_reset", {31'd0, UART_TX}, 32'd1);
        check("irq_async_reset", {31'd0, IRQ}, 32'd1);
        frame_q.delete();
        repeat (2) @(posedge HCLK);
        #1;
        SI_Reset = 1'b0;
        ahb_read(32'h4, 32'h0000_0004, "status_after_reset");
        ahb_read(32'h8, 32'd434, "divisor_after_reset");
        repeat (400) @(posedge HCLK);
        #1;
        check("tx_idle_after_reset", {31'd0, UART_TX}, 32'd1);

        repeat (4) @(posedge HCLK);
        #1;
        check("frames_pending", frame_q.size(), 32'd0);
        check("reads_pending", rd_exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
